// File: rtl/layer_three_dense.sv
// Final dense classifier: streams 10 class weight vectors in 14-bit words,
// scores each class by XNOR-popcount against the feature map and reports the argmax.
module layer_three_dense #(
    parameter int         N_IN      = 196,
    parameter int         N_CLASS   = 10,
    parameter int         CHUNK     = 14,
    parameter logic [2:0] S_LAYER_3 = 3'b100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic [N_IN-1:0]  features,
    output logic             wt_req,
    output logic [7:0]       wt_addr,
    input  logic             wt_valid,
    input  logic [CHUNK-1:0] wt_data,
    output logic [3:0]       digit,
    output logic [7:0]       score,
    output logic             done
);

    localparam int         N_CHUNK    = N_IN / CHUNK;
    localparam logic [3:0] LAST_CHUNK = 4'(N_CHUNK - 1);
    localparam logic [3:0] LAST_CLASS = 4'(N_CLASS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

    st_t st_q, st_d;

    logic [3:0]       cls_q, chunk_q, best_class_q, digit_q;
    logic [7:0]       acc_q, addr_q, best_score_q, score_q;
    logic [CHUNK-1:0] xn;
    logic [3:0]       pc;
    logic [7:0]       class_sum;
    logic             enabled, xfer, last_chunk, last_class, take;
    logic [7:0]       new_best_score;
    logic [3:0]       new_best_class;

    assign enabled    = (state == S_LAYER_3);
    assign xfer       = (st_q == RUN) && enabled && wt_valid;
    assign last_chunk = (chunk_q == LAST_CHUNK);
    assign last_class = (cls_q == LAST_CLASS);

    always_comb begin
        xn = ~(features[int'(chunk_q)*CHUNK +: CHUNK] ^ wt_data);
        pc = '0;
        for (int unsigned j = 0; j < CHUNK; j++) begin
            pc = pc + {3'b000, xn[j]};
        end
        class_sum = acc_q + 8'(pc);
        // Strict greater-than keeps the lower class index on ties
        take           = (cls_q == '0) || (class_sum > best_score_q);
        new_best_score = take ? class_sum : best_score_q;
        new_best_class = take ? cls_q : best_class_q;
    end

    always_ff @(posedge clk) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE: if (enabled) st_d = RUN;
            RUN: begin
                if (!enabled)                              st_d = IDLE;
                else if (xfer && last_chunk && last_class) st_d = DONE;
            end
            DONE:    st_d = DONE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        wt_req  = (st_q == RUN);
        done    = (st_q == DONE);
        wt_addr = (st_q == RUN) ? addr_q : '0;
        digit   = digit_q;
        score   = score_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cls_q        <= '0;
            chunk_q      <= '0;
            acc_q        <= '0;
            addr_q       <= '0;
            best_class_q <= '0;
            best_score_q <= '0;
            digit_q      <= '0;
            score_q      <= '0;
        end else begin
            if (st_q == IDLE && enabled) begin
                cls_q   <= '0;
                chunk_q <= '0;
                acc_q   <= '0;
                addr_q  <= '0;
            end
            if (xfer) begin
                addr_q <= addr_q + 8'd1;
                if (!last_chunk) begin
                    acc_q   <= class_sum;
                    chunk_q <= chunk_q + 4'd1;
                end else begin
                    acc_q        <= '0;
                    chunk_q      <= '0;
                    cls_q        <= cls_q + 4'd1;
                    best_score_q <= new_best_score;
                    best_class_q <= new_best_class;
                    if (last_class) begin
                        digit_q <= new_best_class;
                        score_q <= new_best_score;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_three_dense.sv
// Self-checking bench for layer_three_dense: weight store model plus a
// match-count argmax reference computed directly from features and weights.
module tb_layer_three_dense;

    localparam logic [2:0] S3 = 3'b100;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   state;
    logic [195:0] feat;
    logic         wt_req;
    logic [7:0]   wt_addr;
    logic         wt_valid;
    logic [13:0]  wt_data;
    logic [3:0]   digit;
    logic [7:0]   score;
    logic         done;

    logic [195:0] W [10];
    logic [7:0]   xfer_q [$];
    int           compared = 0;
    int           mismatched = 0;

    always #5 clk = ~clk;

    layer_three_dense #(.N_IN(196), .N_CLASS(10), .CHUNK(14), .S_LAYER_3(3'b100)) dut (
        .clk(clk), .rst(rst), .state(state), .features(feat),
        .wt_req(wt_req), .wt_addr(wt_addr), .wt_valid(wt_valid), .wt_data(wt_data),
        .digit(digit), .score(score), .done(done)
    );

    // Weight store: word a holds class a/14, feature bits (a%14)*14 +: 14
    always_comb begin
        int a;
        a = int'(wt_addr);
        wt_data = '0;
        if (a < 140) wt_data = W[a/14][(a%14)*14 +: 14];
    end

    always @(posedge clk) begin
        if (!rst && state == S3 && wt_req && wt_valid) xfer_q.push_back(wt_addr);
    end

    function automatic void model(output logic [3:0] d, output logic [7:0] s);
        int best, bc, sc;
        best = 0; bc = 0;
        for (int c = 0; c < 10; c++) begin
            sc = 0;
            for (int i = 0; i < 196; i++) if (feat[i] == W[c][i]) sc++;
            if (c == 0 || sc > best) begin best = sc; bc = c; end
        end
        d = 4'(bc);
        s = 8'(best);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; state = 3'b000; wt_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Caller is just past a negedge; the next posedge is E0.
    task automatic run(input int prob, output int edges, output int stalls,
                       output int hold_err, output bit timeout);
        logic [7:0] pa;
        bit pstall;
        edges = 0; stalls = 0; hold_err = 0; timeout = 1'b0; pstall = 1'b0; pa = '0;
        xfer_q.delete();
        state = S3; wt_valid = 1'b0;
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            if (pstall && wt_addr !== pa) hold_err++;
            if (done) break;
            if (edges >= 2000) begin timeout = 1'b1; break; end
            wt_valid = (int'($urandom_range(99)) < prob);
            pstall = !wt_valid;
            pa = wt_addr;
            if (!wt_valid) stalls++;
            @(posedge clk);
            edges++;
        end
        wt_valid = 1'b0;
    endtask

    task automatic build_w(input int c, input int nmatch);
        int nflip, flipped, p;
        W[c] = feat; nflip = 196 - nmatch; flipped = 0;
        while (flipped < nflip) begin
            p = int'($urandom_range(195));
            if (W[c][p] == feat[p]) begin W[c][p] = ~W[c][p]; flipped++; end
        end
    endtask

    task automatic test_reset();
        state = S3; wt_valid = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        compared++; if (done !== 1'b0)     begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
        compared++; if (digit !== 4'd0)    begin mismatched++; $display("FAIL reset_digit: got %0d want 0", digit); end
        compared++; if (score !== 8'd0)    begin mismatched++; $display("FAIL reset_score: got %0d want 0", score); end
        compared++; if (wt_req !== 1'b0)   begin mismatched++; $display("FAIL reset_wt_req: got %b want 0", wt_req); end
        compared++; if (wt_addr !== 8'd0)  begin mismatched++; $display("FAIL reset_wt_addr: got %0d want 0", wt_addr); end
        rst = 1'b0; state = 3'b000; wt_valid = 1'b0;
    endtask

    task automatic test_all_zero();
        int e, st, he, bad; bit to;
        do_reset();
        feat = '0;
        for (int c = 0; c < 10; c++) W[c] = '0;
        run(100, e, st, he, to);
        compared++; if (to)               begin mismatched++; $display("FAIL zero_timeout: got timeout want done"); end
        compared++; if (done !== 1'b1)    begin mismatched++; $display("FAIL zero_done: got %b want 1", done); end
        compared++; if (digit !== 4'd0)   begin mismatched++; $display("FAIL zero_digit: got %0d want 0", digit); end
        compared++; if (score !== 8'd196) begin mismatched++; $display("FAIL zero_score: got %0d want 196", score); end
        compared++; if (e != 140)         begin mismatched++; $display("FAIL zero_latency: got %0d want 140", e); end
        bad = 0;
        if (xfer_q.size() != 140) bad = 1;
        else for (int i = 0; i < 140; i++) if (xfer_q[i] !== 8'(i)) bad++;
        compared++; if (bad != 0) begin mismatched++; $display("FAIL zero_addr_seq: got %0d bad (n=%0d) want 0", bad, xfer_q.size()); end
    endtask

    task automatic test_class7();
        int e, st, he; bit to;
        do_reset();
        feat = '0;
        for (int c = 0; c < 10; c++) W[c] = (c == 7) ? '0 : '1;
        run(100, e, st, he, to);
        compared++; if (to || done !== 1'b1) begin mismatched++; $display("FAIL c7_done: got %b (to=%0d) want 1", done, to); end
        compared++; if (digit !== 4'd7)      begin mismatched++; $display("FAIL c7_digit: got %0d want 7", digit); end
        compared++; if (score !== 8'd196)    begin mismatched++; $display("FAIL c7_score: got %0d want 196", score); end
    endtask

    task automatic test_alt(input int prob);
        int e, st, he, bad; bit to;
        logic [3:0] md; logic [7:0] ms;
        do_reset();
        for (int i = 0; i < 196; i++) feat[i] = (i % 2 == 1);
        for (int c = 0; c < 10; c++) build_w(c, (c == 3) ? 150 : (c == 8) ? 151 : 98);
        model(md, ms);
        run(prob, e, st, he, to);
        compared++; if (to || done !== 1'b1) begin mismatched++; $display("FAIL alt%0d_done: got %b want 1", prob, done); end
        compared++; if (digit !== 4'd8 || md !== 4'd8)   begin mismatched++; $display("FAIL alt%0d_digit: got %0d want 8 (model %0d)", prob, digit, md); end
        compared++; if (score !== 8'd151 || ms !== 8'd151) begin mismatched++; $display("FAIL alt%0d_score: got %0d want 151 (model %0d)", prob, score, ms); end
        compared++; if (e != 140 + st)       begin mismatched++; $display("FAIL alt%0d_latency: got %0d want %0d", prob, e, 140 + st); end
        compared++; if (he != 0)             begin mismatched++; $display("FAIL alt%0d_stall_hold: got %0d moves want 0", prob, he); end
        bad = 0;
        if (xfer_q.size() != 140) bad = 1;
        else for (int i = 0; i < 140; i++) if (xfer_q[i] !== 8'(i)) bad++;
        compared++; if (bad != 0) begin mismatched++; $display("FAIL alt%0d_addr_seq: got %0d bad (n=%0d) want 0", prob, bad, xfer_q.size()); end
    endtask

    task automatic test_abort();
        int e, st, he, n; bit to;
        logic [3:0] md; logic [7:0] ms;
        do_reset();
        for (int i = 0; i < 196; i++) feat[i] = 1'($urandom_range(1));
        for (int c = 0; c < 10; c++) for (int i = 0; i < 196; i++) W[c][i] = 1'($urandom_range(1));
        model(md, ms);
        state = S3; wt_valid = 1'b1; n = 0;
        while (n < 300 && !(wt_req && wt_addr >= 8'd60)) begin @(negedge clk); n++; end
        compared++; if (n >= 300) begin mismatched++; $display("FAIL abort_reach_class4: got timeout want addr>=60"); end
        state = 3'b000;
        @(negedge clk);
        wt_valid = 1'b0;
        compared++; if (wt_req !== 1'b0) begin mismatched++; $display("FAIL abort_wt_req: got %b want 0", wt_req); end
        compared++; if (done !== 1'b0)   begin mismatched++; $display("FAIL abort_done: got %b want 0", done); end
        compared++; if (digit !== 4'd0 || score !== 8'd0) begin mismatched++; $display("FAIL abort_hold: got %0d/%0d want 0/0", digit, score); end
        @(negedge clk);
        run(70, e, st, he, to);
        compared++; if (to || done !== 1'b1) begin mismatched++; $display("FAIL rerun_done: got %b want 1", done); end
        compared++; if (xfer_q.size() != 140 || xfer_q[0] !== 8'd0) begin mismatched++; $display("FAIL rerun_addr: got n=%0d want 140 from 0", xfer_q.size()); end
        compared++; if (digit !== md || score !== ms) begin mismatched++; $display("FAIL rerun_result: got %0d/%0d want %0d/%0d", digit, score, md, ms); end
    endtask

    task automatic test_reset_in_done();
        int e, st, he; bit to;
        logic [3:0] md; logic [7:0] ms;
        model(md, ms);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rstdone_done: got %b want 0", done); end
        compared++; if (digit !== 4'd0 || score !== 8'd0) begin mismatched++; $display("FAIL rstdone_result: got %0d/%0d want 0/0", digit, score); end
        run(100, e, st, he, to);
        compared++; if (to || done !== 1'b1) begin mismatched++; $display("FAIL rstdone_rerun: got %b want 1", done); end
        compared++; if (e != 140 || xfer_q.size() != 140) begin mismatched++; $display("FAIL rstdone_latency: got %0d/%0d want 140", e, xfer_q.size()); end
        compared++; if (digit !== md || score !== ms) begin mismatched++; $display("FAIL rstdone_value: got %0d/%0d want %0d/%0d", digit, score, md, ms); end
    endtask

    task automatic test_random();
        int e, st, he; bit to;
        logic [3:0] md; logic [7:0] ms;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            for (int i = 0; i < 196; i++) feat[i] = 1'($urandom_range(1));
            for (int c = 0; c < 10; c++) for (int i = 0; i < 196; i++) W[c][i] = 1'($urandom_range(1));
            model(md, ms);
            run(60, e, st, he, to);
            compared++; if (to || done !== 1'b1) begin mismatched++; $display("FAIL rand%0d_done: got %b want 1", k, done); end
            compared++; if (digit !== md || score !== ms) begin mismatched++; $display("FAIL rand%0d_result: got %0d/%0d want %0d/%0d", k, digit, score, md, ms); end
            compared++; if (e != 140 + st || he != 0) begin mismatched++; $display("FAIL rand%0d_timing: got %0d (hold %0d) want %0d", k, e, he, 140 + st); end
        end
    endtask

    initial begin
        rst = 1'b1; state = 3'b000; wt_valid = 1'b0; feat = '0;
        for (int c = 0; c < 10; c++) W[c] = '0;
        test_reset();
        test_all_zero();
        test_class7();
        test_alt(100);
        test_alt(50);
        test_abort();
        test_reset_in_done();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
